ahblite_decoder_mux: RTL and testbench

//  Parametrised AHB-Lite address decoder + slave response multiplexer for the Cortex-M0 bus.

---
 rtl/ahblite_decoder_mux.sv | 139 +++++++++++++
 tb/tb_ahblite_decoder_mux.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder, response mux and built-in ERROR default slave for unmapped accesses.
// P_HSEL is combinational from HADDR; the response follows the registered data-phase owner one cycle later.
module ahblite_decoder_mux #(
  parameter int                  NPORT     = 4,
  parameter logic [32*NPORT-1:0] ADDR_BASE = {32'h40050000, 32'h40000000, 32'h20000000, 32'h00000000},
  parameter logic [32*NPORT-1:0] ADDR_MASK = {32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000},
  parameter logic [NPORT-1:0]    PORT_EN   = {NPORT{1'b1}},
  parameter int                  CNT_W     = 16
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NPORT-1:0]      P_HSEL,
  input  logic [NPORT-1:0]      P_HREADYOUT,
  input  logic [NPORT-1:0]      P_HRESP,
  input  logic [32*NPORT-1:0]   P_HRDATA,
  output logic                  HREADY,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [CNT_W-1:0]      miss_cnt,
  output logic [31:0]           miss_addr
);

  localparam int IW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [NPORT-1:0] match;
  logic [NPORT-1:0] hsel;
  logic [IW-1:0]    hit_idx;
  logic             miss;
  logic             unmapped;
  logic             unused_htrans0;

  logic             sel_def_q, sel_def_d;
  logic [IW-1:0]    sel_idx_q, sel_idx_d;
  ds_state_t        state_q, state_d;
  logic             def_ready_q, def_ready_d;
  logic             def_resp_q, def_resp_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [31:0]      miss_addr_q, miss_addr_d;

  assign unused_htrans0 = HTRANS[0];

  // Walk from the top down so the lowest matching port wins on overlap.
  always_comb begin
    hsel    = '0;
    hit_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      match[i] = PORT_EN[i] &&
                 ((HADDR & ADDR_MASK[32*i +: 32]) == (ADDR_BASE[32*i +: 32] & ADDR_MASK[32*i +: 32]));
    end
    for (int i = NPORT-1; i >= 0; i--) begin
      if (match[i]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign P_HSEL   = hsel;
  assign miss     = ~|match;
  assign unmapped = miss && HTRANS[1] && HREADY;

  always_comb begin
    HREADY = def_ready_q;
    HRESP  = def_resp_q;
    HRDATA = '0;
    if (!sel_def_q) begin
      for (int i = 0; i < NPORT; i++) begin
        if (sel_idx_q == IW'(i)) begin
          HREADY = P_HREADYOUT[i];
          HRESP  = P_HRESP[i];
          HRDATA = P_HRDATA[32*i +: 32];
        end
      end
    end
  end

  always_comb begin
    sel_def_d   = sel_def_q;
    sel_idx_d   = sel_idx_q;
    miss_cnt_d  = miss_cnt_q;
    miss_addr_d = miss_addr_q;
    if (HREADY) begin
      sel_def_d = miss;
      sel_idx_d = hit_idx;
    end
    if (unmapped) begin
      miss_addr_d = HADDR;
      if (miss_cnt_q != {CNT_W{1'b1}}) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Default slave: two-cycle ERROR, with ERR2 able to chain straight into another ERR1.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DS_IDLE: if (unmapped) state_d = DS_ERR1;
      DS_ERR1: state_d = DS_ERR2;
      DS_ERR2: state_d = unmapped ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
    def_ready_d = (state_d != DS_ERR1);
    def_resp_d  = (state_d != DS_IDLE);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      sel_def_q   <= 1'b1;
      sel_idx_q   <= '0;
      state_q     <= DS_IDLE;
      def_ready_q <= 1'b1;
      def_resp_q  <= 1'b0;
      miss_cnt_q  <= '0;
      miss_addr_q <= '0;
    end else begin
      sel_def_q   <= sel_def_d;
      sel_idx_q   <= sel_idx_d;
      state_q     <= state_d;
      def_ready_q <= def_ready_d;
      def_resp_q  <= def_resp_d;
      miss_cnt_q  <= miss_cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  assign miss_cnt  = miss_cnt_q;
  assign miss_addr = miss_addr_q;

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Directed bench for ahblite_decoder_mux: the driver queues per-cycle expectations, a negedge monitor checks them.
// A second instance covers disabled ports, overlapping bases and miss counter saturation.
module tb_ahblite_decoder_mux;

  localparam logic [31:0] NONSEQ = 32'd2;
  localparam logic [31:0] IDLE   = 32'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst1, rst2;
  logic [31:0]  haddr1, haddr2;
  logic [1:0]   htrans1, htrans2;
  logic [3:0]   hsel1, hsel2;
  logic [3:0]   hro1, hro2;
  logic [3:0]   hrsp1, hrsp2;
  logic [127:0] hrd;
  logic         hready1, hready2, hresp1, hresp2;
  logic [31:0]  hrdata1, hrdata2, maddr1, maddr2;
  logic [15:0]  mcnt1;
  logic [1:0]   mcnt2;

  assign hrd = {32'h33333333, 32'h22222222, 32'hA5A5A5A5, 32'h11110000};

  ahblite_decoder_mux u_dut1 (
    .HCLK(clk), .HRESET(rst1), .HADDR(haddr1), .HTRANS(htrans1), .P_HSEL(hsel1),
    .P_HREADYOUT(hro1), .P_HRESP(hrsp1), .P_HRDATA(hrd), .HREADY(hready1), .HRESP(hresp1),
    .HRDATA(hrdata1), .miss_cnt(mcnt1), .miss_addr(maddr1)
  );

  ahblite_decoder_mux #(
    .NPORT(4),
    .ADDR_BASE({32'h00000000, 32'h40000000, 32'h20000000, 32'h00000000}),
    .ADDR_MASK({32'hFFFF0000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000}),
    .PORT_EN(4'b1101),
    .CNT_W(2)
  ) u_dut2 (
    .HCLK(clk), .HRESET(rst2), .HADDR(haddr2), .HTRANS(htrans2), .P_HSEL(hsel2),
    .P_HREADYOUT(hro2), .P_HRESP(hrsp2), .P_HRDATA(hrd), .HREADY(hready2), .HRESP(hresp2),
    .HRDATA(hrdata2), .miss_cnt(mcnt2), .miss_addr(maddr2)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          fld;
    logic [31:0] val;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string fname[6] = '{"hsel", "hready", "hresp", "hrdata", "miss_cnt", "miss_addr"};

  localparam int F_HSEL = 0, F_RDY = 1, F_RSP = 2, F_DAT = 3, F_CNT = 4, F_ADR = 5;

  function automatic logic [31:0] actual(int dut, int fld);
    logic [31:0] v;
    v = 'x;
    if (dut == 1) begin
      case (fld)
        F_HSEL: v = {28'd0, hsel1};
        F_RDY:  v = {31'd0, hready1};
        F_RSP:  v = {31'd0, hresp1};
        F_DAT:  v = hrdata1;
        F_CNT:  v = {16'd0, mcnt1};
        default: v = maddr1;
      endcase
    end else begin
      case (fld)
        F_HSEL: v = {28'd0, hsel2};
        F_RDY:  v = {31'd0, hready2};
        F_RSP:  v = {31'd0, hresp2};
        F_DAT:  v = hrdata2;
        F_CNT:  v = {30'd0, mcnt2};
        default: v = maddr2;
      endcase
    end
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] a;
        a = actual(sb[i].dut, sb[i].fld);
        n_tests++;
        if (a !== sb[i].val || sb[i].cyc != cyc) begin
          n_fail++;
          $display("FAIL dut%0d %s cyc %0d: got %h, expected %h", sb[i].dut, fname[sb[i].fld],
                   sb[i].cyc, a, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic chk(int dut, int fld, logic [31:0] v);
    exp_t e;
    e.cyc = cyc;
    e.dut = dut;
    e.fld = fld;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus1(logic [31:0] t, logic [31:0] a);
    htrans1 = t[1:0];
    haddr1  = a;
  endtask

  task automatic bus2(logic [31:0] t, logic [31:0] a);
    htrans2 = t[1:0];
    haddr2  = a;
  endtask

  initial begin
    rst1 = 1'b1; rst2 = 1'b1;
    hro1 = 4'hF; hro2 = 4'hF; hrsp1 = 4'h0; hrsp2 = 4'h0;
    bus1(IDLE, 32'h0); bus2(IDLE, 32'h0);
    tick();
    n_tests++;
    if (hready1 !== 1'b1) begin
        n_fail++;
        $display("FAIL direct hready after reset: got %b", hready1);
    end
    // Reset state.
    rst1 = 1'b0;
    chk(1, F_RDY, 1); chk(1, F_RSP, 0); chk(1, F_DAT, 0); chk(1, F_CNT, 0); chk(1, F_ADR, 0);
    // Plain read from slave 1.
    bus1(NONSEQ, 32'h20000010); chk(1, F_HSEL, 4'b0010);
    tick();
    n_tests++;
    if (hrdata1 !== 32'hA5A5A5A5) begin
        n_fail++;
        $display("FAIL direct hrdata slave1: got %h", hrdata1);
    end
    chk(1, F_DAT, 32'hA5A5A5A5); chk(1, F_RDY, 1); chk(1, F_RSP, 0);
    // Slave 2 inserts three wait states; next address held until HREADY.
    bus1(NONSEQ, 32'h40000004); chk(1, F_HSEL, 4'b0100);
    tick();
    hro1[2] = 1'b0; bus1(NONSEQ, 32'h00000000);
    chk(1, F_RDY, 0); chk(1, F_HSEL, 4'b0001); chk(1, F_DAT, 32'h22222222);
    tick(); chk(1, F_RDY, 0);
    tick(); chk(1, F_RDY, 0); chk(1, F_DAT, 32'h22222222);
    tick(); hro1[2] = 1'b1; chk(1, F_RDY, 1); chk(1, F_DAT, 32'h22222222);
    tick();
    chk(1, F_DAT, 32'h11110000); chk(1, F_RDY, 1); chk(1, F_RSP, 0);
    // IDLE to an unmapped address: OKAY, no wait, no count.
    bus1(IDLE, 32'h30000000); chk(1, F_HSEL, 4'b0000);
    tick();
    chk(1, F_RDY, 1); chk(1, F_RSP, 0); chk(1, F_DAT, 0); chk(1, F_CNT, 0);
    // Unmapped NONSEQ, then a second one chained out of ERR2.
    bus1(NONSEQ, 32'h30000000);
    tick();
    n_tests++;
    if (mcnt1 !== 16'd1) begin
        n_fail++;
        $display("FAIL direct miss_cnt: got %0d", mcnt1);
    end
    n_tests++;
    if (maddr1 !== 32'h30000000) begin
        n_fail++;
        $display("FAIL direct miss_addr: got %h", maddr1);
    end
    chk(1, F_RDY, 0); chk(1, F_RSP, 1); chk(1, F_CNT, 1); chk(1, F_ADR, 32'h30000000);
    bus1(NONSEQ, 32'h30000004);
    tick();
    chk(1, F_RDY, 1); chk(1, F_RSP, 1); chk(1, F_CNT, 1);
    tick();
    chk(1, F_RDY, 0); chk(1, F_RSP, 1); chk(1, F_CNT, 2); chk(1, F_ADR, 32'h30000004);
    bus1(IDLE, 32'h0);
    tick();
    chk(1, F_RDY, 1); chk(1, F_RSP, 1);
    tick();
    chk(1, F_RDY, 1); chk(1, F_RSP, 0); chk(1, F_DAT, 32'h11110000);
    // Reset in the middle of ERR1.
    bus1(NONSEQ, 32'h30000000);
    tick();
    chk(1, F_RDY, 0); chk(1, F_RSP, 1); chk(1, F_CNT, 3);
    rst1 = 1'b1; bus1(IDLE, 32'h0);
    tick();
    rst1 = 1'b0;
    chk(1, F_RDY, 1); chk(1, F_RSP, 0); chk(1, F_DAT, 0); chk(1, F_CNT, 0); chk(1, F_ADR, 0);
    bus1(NONSEQ, 32'h40050008); chk(1, F_HSEL, 4'b1000);
    tick();
    chk(1, F_DAT, 32'h33333333); chk(1, F_RDY, 1);
    bus1(IDLE, 32'h0);

    // Second instance: port 1 disabled, ports 0 and 3 overlap, 2-bit miss counter.
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    chk(2, F_CNT, 0); chk(2, F_RDY, 1);
    bus2(NONSEQ, 32'h00000100); chk(2, F_HSEL, 4'b0001);
    tick();
    chk(2, F_DAT, 32'h11110000);
    bus2(NONSEQ, 32'h20000000); chk(2, F_HSEL, 4'b0000);
    tick();
    chk(2, F_RDY, 0); chk(2, F_RSP, 1); chk(2, F_CNT, 1); chk(2, F_ADR, 32'h20000000);
    bus2(IDLE, 32'h0);
    tick();
    chk(2, F_RDY, 1); chk(2, F_RSP, 1);
    bus2(NONSEQ, 32'h30000000);
    tick();
    chk(2, F_CNT, 2); chk(2, F_RDY, 0);
    bus2(NONSEQ, 32'h50000000);
    tick();
    tick();
    chk(2, F_CNT, 3); chk(2, F_ADR, 32'h50000000);
    bus2(NONSEQ, 32'h60000000);
    tick();
    tick();
    n_tests++;
    if (mcnt2 !== 2'b11) begin
        n_fail++;
        $display("FAIL direct miss_cnt saturation: got %0d", mcnt2);
    end
    chk(2, F_CNT, 3); chk(2, F_ADR, 32'h60000000); chk(2, F_RDY, 0);
    bus2(IDLE, 32'h0);
    tick();
    chk(2, F_RDY, 1); chk(2, F_RSP, 1);
    tick();
    chk(2, F_RDY, 1); chk(2, F_RSP, 0); chk(2, F_DAT, 32'h11110000);

    tick();
    tick();
    while (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unchecked %s dut%0d cyc %0d: got nothing, expected %h", fname[sb[0].fld],
               sb[0].dut, sb[0].cyc, sb[0].val);
      void'(sb.pop_front());
    end
    if (n_fail != 0) begin
        $display("[TB] FAILED");
    end else begin
        $display("[TB] PASSED");
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
